// File: rtl/order_book_pt.sv
// rtl/order_book_pt.sv - price-time-priority limit order book with ML circuit breaker
module order_book_pt #(
    parameter int DEPTH   = 8,
    parameter int PRICE_W = 7,
    parameter int QTY_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_in_valid,
    input  logic                       i_in_side,
    input  logic [PRICE_W-1:0]         i_in_price,
    input  logic [QTY_W-1:0]           i_in_qty,
    output logic                       o_in_ready,
    input  logic [1:0]                 i_cb_mode,
    input  logic [7:0]                 i_cb_param,
    input  logic                       i_cb_load,
    output logic                       o_match_valid,
    output logic [PRICE_W-1:0]         o_match_price,
    output logic [QTY_W-1:0]           o_match_qty,
    output logic                       o_reject,
    output logic [$clog2(DEPTH+1)-1:0] o_bid_count,
    output logic [$clog2(DEPTH+1)-1:0] o_ask_count,
    output logic                       o_cb_active,
    output logic [1:0]                 o_cb_state
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        CB_NORMAL   = 2'b00,
        CB_THROTTLE = 2'b01,
        CB_WIDEN    = 2'b10,
        CB_PAUSE    = 2'b11
    } cb_state_t;

    // Circuit breaker state; only the upper nibble of the ML parameter is needed after load
    cb_state_t        r_cb_state;
    logic [3:0]       r_cb_param_hi;
    logic [8:0]       r_cb_cnt;
    logic [3:0]       r_thr_cnt;

    // Resting book, one array set per side
    logic [DEPTH-1:0]   r_bid_v;
    logic [PRICE_W-1:0] r_bid_px  [DEPTH];
    logic [QTY_W-1:0]   r_bid_qty [DEPTH];
    logic [3:0]         r_bid_age [DEPTH];
    logic [DEPTH-1:0]   r_ask_v;
    logic [PRICE_W-1:0] r_ask_px  [DEPTH];
    logic [QTY_W-1:0]   r_ask_qty [DEPTH];
    logic [3:0]         r_ask_age [DEPTH];

    logic               r_match_valid;
    logic [PRICE_W-1:0] r_match_price;
    logic [QTY_W-1:0]   r_match_qty;
    logic               r_reject;

    logic               w_bb_found, w_ba_found;
    logic [IW-1:0]      w_bb_idx, w_ba_idx;
    logic               w_bid_full, w_ask_full;
    logic [IW-1:0]      w_bid_free, w_ask_free;
    logic [CW-1:0]      w_bid_cnt, w_ask_cnt;
    logic               w_accept, w_drop, w_ins_bid, w_ins_ask, w_side_full;
    logic [2:0]         w_guard;
    logic [PRICE_W:0]   w_ask_lim;
    logic               w_cross, w_fill;
    logic [QTY_W-1:0]   w_fill_qty;

    assign o_in_ready = (r_cb_state != CB_PAUSE) &&
                        ((r_cb_state != CB_THROTTLE) || (r_thr_cnt == 4'd0));

    // Best bid: highest price, then oldest, then lowest slot
    always_comb begin
        w_bb_found = 1'b0;
        w_bb_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_bid_v[i]) begin
                if (!w_bb_found || (r_bid_px[i] > r_bid_px[w_bb_idx]) ||
                    ((r_bid_px[i] == r_bid_px[w_bb_idx]) && (r_bid_age[i] > r_bid_age[w_bb_idx]))) begin
                    w_bb_found = 1'b1;
                    w_bb_idx   = IW'(i);
                end
            end
        end
    end

    // Best ask: lowest price, then oldest, then lowest slot
    always_comb begin
        w_ba_found = 1'b0;
        w_ba_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_ask_v[i]) begin
                if (!w_ba_found || (r_ask_px[i] < r_ask_px[w_ba_idx]) ||
                    ((r_ask_px[i] == r_ask_px[w_ba_idx]) && (r_ask_age[i] > r_ask_age[w_ba_idx]))) begin
                    w_ba_found = 1'b1;
                    w_ba_idx   = IW'(i);
                end
            end
        end
    end

    // Lowest free slot and live count per side, from the registered book
    always_comb begin
        w_bid_full = 1'b1;
        w_ask_full = 1'b1;
        w_bid_free = '0;
        w_ask_free = '0;
        w_bid_cnt  = '0;
        w_ask_cnt  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_bid_v[i]) begin
                w_bid_full = 1'b0;
                w_bid_free = IW'(i);
            end
            if (!r_ask_v[i]) begin
                w_ask_full = 1'b0;
                w_ask_free = IW'(i);
            end
            w_bid_cnt = w_bid_cnt + CW'(r_bid_v[i]);
            w_ask_cnt = w_ask_cnt + CW'(r_ask_v[i]);
        end
    end

    assign w_accept    = i_in_valid && o_in_ready;
    assign w_side_full = i_in_side ? w_ask_full : w_bid_full;
    assign w_drop      = w_accept && ((i_in_qty == '0) || w_side_full);
    assign w_ins_bid   = w_accept && !w_drop && !i_in_side;
    assign w_ins_ask   = w_accept && !w_drop && i_in_side;

    // Crossing test is one bit wider than the price so ask+guard never wraps
    assign w_guard    = (r_cb_state == CB_WIDEN) ? r_cb_param_hi[3:1] : 3'd0;
    assign w_ask_lim  = {1'b0, r_ask_px[w_ba_idx]} + {{(PRICE_W-2){1'b0}}, w_guard};
    assign w_cross    = w_bb_found && w_ba_found && ({1'b0, r_bid_px[w_bb_idx]} >= w_ask_lim);
    assign w_fill     = w_cross && (r_cb_state != CB_PAUSE);
    assign w_fill_qty = (r_bid_qty[w_bb_idx] < r_ask_qty[w_ba_idx]) ?
                        r_bid_qty[w_bb_idx] : r_ask_qty[w_ba_idx];

    // Book update: ageing, fill decrement/free, and insert into a slot that was free before the edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bid_v <= '0;
            r_ask_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_bid_px[i]  <= '0;
                r_bid_qty[i] <= '0;
                r_bid_age[i] <= '0;
                r_ask_px[i]  <= '0;
                r_ask_qty[i] <= '0;
                r_ask_age[i] <= '0;
            end
        end else begin
            if (r_cb_state != CB_PAUSE) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_bid_age[i] != 4'hF) r_bid_age[i] <= r_bid_age[i] + 4'd1;
                    if (r_ask_age[i] != 4'hF) r_ask_age[i] <= r_ask_age[i] + 4'd1;
                end
            end
            if (w_fill) begin
                r_bid_qty[w_bb_idx] <= r_bid_qty[w_bb_idx] - w_fill_qty;
                r_ask_qty[w_ba_idx] <= r_ask_qty[w_ba_idx] - w_fill_qty;
                if (r_bid_qty[w_bb_idx] == w_fill_qty) r_bid_v[w_bb_idx] <= 1'b0;
                if (r_ask_qty[w_ba_idx] == w_fill_qty) r_ask_v[w_ba_idx] <= 1'b0;
            end
            if (w_ins_bid) begin
                r_bid_v[w_bid_free]   <= 1'b1;
                r_bid_px[w_bid_free]  <= i_in_price;
                r_bid_qty[w_bid_free] <= i_in_qty;
                r_bid_age[w_bid_free] <= 4'd0;
            end
            if (w_ins_ask) begin
                r_ask_v[w_ask_free]   <= 1'b1;
                r_ask_px[w_ask_free]  <= i_in_price;
                r_ask_qty[w_ask_free] <= i_in_qty;
                r_ask_age[w_ask_free] <= 4'd0;
            end
        end
    end

    // Registered fill and reject pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match_valid <= 1'b0;
            r_match_price <= '0;
            r_match_qty   <= '0;
            r_reject      <= 1'b0;
        end else begin
            r_match_valid <= w_fill;
            r_match_price <= w_fill ? r_ask_px[w_ba_idx] : '0;
            r_match_qty   <= w_fill ? w_fill_qty : '0;
            r_reject      <= w_drop;
        end
    end

    // Circuit breaker: load overrides everything, otherwise count down and self-heal to NORMAL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cb_state    <= CB_NORMAL;
            r_cb_param_hi <= '0;
            r_cb_cnt      <= '0;
            r_thr_cnt     <= '0;
        end else if (i_cb_load) begin
            r_cb_state    <= cb_state_t'(i_cb_mode);
            r_cb_param_hi <= i_cb_param[7:4];
            r_thr_cnt     <= '0;
            case (cb_state_t'(i_cb_mode))
                CB_NORMAL: r_cb_cnt <= '0;
                CB_PAUSE:  r_cb_cnt <= {i_cb_param, 1'b0};
                default:   r_cb_cnt <= {1'b0, i_cb_param};
            endcase
        end else if (r_cb_state != CB_NORMAL) begin
            if (r_cb_state == CB_THROTTLE)
                r_thr_cnt <= (r_thr_cnt == r_cb_param_hi) ? 4'd0 : r_thr_cnt + 4'd1;
            if (r_cb_cnt != '0) begin
                r_cb_cnt <= r_cb_cnt - 9'd1;
            end else begin
                r_cb_state <= CB_NORMAL;
                r_thr_cnt  <= '0;
            end
        end
    end

    assign o_match_valid = r_match_valid;
    assign o_match_price = r_match_price;
    assign o_match_qty   = r_match_qty;
    assign o_reject      = r_reject;
    assign o_bid_count   = w_bid_cnt;
    assign o_ask_count   = w_ask_cnt;
    assign o_cb_state    = r_cb_state;
    assign o_cb_active   = (r_cb_state != CB_NORMAL);

endmodule

// File: tb/tb_order_book_pt.sv
// tb/tb_order_book_pt.sv - randomized bench for order_book_pt against a behavioural book model
module tb_order_book_pt;
    localparam int DEPTH   = 8;
    localparam int PRICE_W = 7;
    localparam int QTY_W   = 4;
    localparam int CW      = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_side = 1'b0;
    logic [PRICE_W-1:0] in_price = '0;
    logic [QTY_W-1:0]   in_qty = '0;
    logic               in_ready;
    logic [1:0]         cb_mode = '0;
    logic [7:0]         cb_param = '0;
    logic               cb_load = 1'b0;
    logic               match_valid;
    logic [PRICE_W-1:0] match_price;
    logic [QTY_W-1:0]   match_qty;
    logic               reject;
    logic [CW-1:0]      bid_count, ask_count;
    logic               cb_active;
    logic [1:0]         cb_state;

    always #5 clk = ~clk;

    order_book_pt #(.DEPTH(DEPTH), .PRICE_W(PRICE_W), .QTY_W(QTY_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .i_in_side(in_side), .i_in_price(in_price), .i_in_qty(in_qty),
        .o_in_ready(in_ready),
        .i_cb_mode(cb_mode), .i_cb_param(cb_param), .i_cb_load(cb_load),
        .o_match_valid(match_valid), .o_match_price(match_price), .o_match_qty(match_qty),
        .o_reject(reject), .o_bid_count(bid_count), .o_ask_count(ask_count),
        .o_cb_active(cb_active), .o_cb_state(cb_state)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: side 0 = bids, 1 = asks; one entry per slot
    int m_v   [2][DEPTH];
    int m_px  [2][DEPTH];
    int m_qty [2][DEPTH];
    int m_age [2][DEPTH];
    int m_mode, m_param, m_cd, m_tc;
    int e_mv, e_mp, e_mq, e_rej;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_ready();
        return int'((m_mode != 3) && (m_mode != 1 || m_tc == 0));
    endfunction

    function automatic int m_count(input int s);
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += m_v[s][i];
        return c;
    endfunction

    function automatic int m_best(input int s);
        int b = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_v[s][i] != 0) begin
                if (b < 0) b = i;
                else if (m_px[s][i] != m_px[s][b]) begin
                    if ((s == 0) ? (m_px[s][i] > m_px[s][b]) : (m_px[s][i] < m_px[s][b])) b = i;
                end else if (m_age[s][i] > m_age[s][b]) b = i;
            end
        end
        return b;
    endfunction

    function automatic int m_free(input int s);
        for (int i = 0; i < DEPTH; i++) if (m_v[s][i] == 0) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++) begin
                m_v[s][i] = 0; m_px[s][i] = 0; m_qty[s][i] = 0; m_age[s][i] = 0;
            end
        m_mode = 0; m_param = 0; m_cd = 0; m_tc = 0;
        e_mv = 0; e_mp = 0; e_mq = 0; e_rej = 0;
    endtask

    // One clock edge of the book, using the inputs present at that edge
    task automatic model_step();
        int acc, bi, ai, guard, fill, q, side, fr, p;
        acc   = int'(in_valid) & m_ready();
        bi    = m_best(0);
        ai    = m_best(1);
        guard = (m_mode == 2) ? (m_param >> 5) : 0;
        fill  = (bi >= 0 && ai >= 0 && m_px[0][bi] >= m_px[1][ai] + guard && m_mode != 3) ? 1 : 0;
        side  = int'(in_side);
        fr    = m_free(side);
        e_mv  = fill;
        e_mp  = 0;
        e_mq  = 0;
        e_rej = (acc != 0 && (in_qty == 0 || fr < 0)) ? 1 : 0;
        if (m_mode != 3)
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < DEPTH; i++)
                    if (m_age[s][i] < 15) m_age[s][i]++;
        if (fill != 0) begin
            q = (m_qty[0][bi] < m_qty[1][ai]) ? m_qty[0][bi] : m_qty[1][ai];
            e_mp = m_px[1][ai];
            e_mq = q;
            m_qty[0][bi] -= q;
            m_qty[1][ai] -= q;
            if (m_qty[0][bi] == 0) m_v[0][bi] = 0;
            if (m_qty[1][ai] == 0) m_v[1][ai] = 0;
        end
        if (acc != 0 && e_rej == 0) begin
            m_v[side][fr] = 1; m_px[side][fr] = int'(in_price);
            m_qty[side][fr] = int'(in_qty); m_age[side][fr] = 0;
        end
        if (cb_load) begin
            p = int'(cb_param);
            m_mode = int'(cb_mode);
            m_param = p;
            m_tc = 0;
            m_cd = (m_mode == 0) ? 0 : (m_mode == 3) ? 2 * p : p;
        end else if (m_mode != 0) begin
            if (m_mode == 1) m_tc = (m_tc == (m_param >> 4)) ? 0 : m_tc + 1;
            if (m_cd > 0) m_cd--;
            else begin m_mode = 0; m_tc = 0; end
        end
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), m_ready());
        chk("bid_count", 32'(bid_count), m_count(0));
        chk("ask_count", 32'(ask_count), m_count(1));
        chk("cb_state", 32'(cb_state), m_mode);
        chk("cb_active", 32'(cb_active), int'(m_mode != 0));
        chk("match_valid", 32'(match_valid), e_mv);
        if (e_mv != 0) begin
            chk("match_price", 32'(match_price), e_mp);
            chk("match_qty", 32'(match_qty), e_mq);
        end
        chk("reject", 32'(reject), e_rej);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; cb_load = 1'b0;
        #1;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic send(input int side, input int px, input int q);
        in_valid = 1'b1; in_side = side[0]; in_price = PRICE_W'(px); in_qty = QTY_W'(q);
        step();
        in_valid = 1'b0;
    endtask

    task automatic load(input int mode, input int param);
        cb_load = 1'b1; cb_mode = mode[1:0]; cb_param = param[7:0];
        step();
        cb_load = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();
        chk("rst_bid_count", 32'(bid_count), 0);
        chk("rst_match_valid", 32'(match_valid), 0);
        chk("rst_cb_state", 32'(cb_state), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        // T1: partial fill at the ask price, remainder rests
        send(0, 50, 3);
        send(1, 48, 5);
        step();
        chk("t1_match_valid", 32'(match_valid), 1);
        chk("t1_match_price", 32'(match_price), 48);
        chk("t1_match_qty", 32'(match_qty), 3);
        chk("t1_bid_count", 32'(bid_count), 0);
        chk("t1_ask_count", 32'(ask_count), 1);
        step();
        chk("t1_pulse_end", 32'(match_valid), 0);

        // T2: time priority between equal bids
        do_reset();
        send(0, 60, 1);
        step();
        send(0, 60, 1);
        send(1, 55, 1);
        step();
        chk("t2_match_price", 32'(match_price), 55);
        chk("t2_bid_count", 32'(bid_count), 1);
        chk("t2_ask_count", 32'(ask_count), 0);

        // T3: full side rejects
        do_reset();
        for (int i = 0; i < DEPTH; i++) send(0, 10 + i, 1);
        chk("t3_ready", 32'(in_ready), 1);
        send(0, 30, 1);
        chk("t3_reject", 32'(reject), 1);
        chk("t3_bid_count", 32'(bid_count), DEPTH);
        step();
        chk("t3_reject_end", 32'(reject), 0);

        // T4: PAUSE for 2*3+1 cycles holds a crossing book
        do_reset();
        send(0, 50, 2);
        cb_load = 1'b1; cb_mode = 2'b11; cb_param = 8'd3;
        send(1, 45, 1);
        cb_load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("t4_paused_ready", 32'(in_ready), 0);
            chk("t4_paused_match", 32'(match_valid), 0);
            step();
        end
        chk("t4_resumed_state", 32'(cb_state), 0);
        chk("t4_resumed_match", 32'(match_valid), 0);
        step();
        chk("t4_fill", 32'(match_valid), 1);
        chk("t4_fill_price", 32'(match_price), 45);

        // T5: WIDEN guard of 3 ticks, and no wrap near the top of the price range
        do_reset();
        load(2, 8'h60);
        send(0, 52, 1);
        send(1, 50, 1);
        step();
        step();
        chk("t5_guard_hold", 32'(match_valid), 0);
        send(0, 53, 1);
        step();
        chk("t5_guard_fill", 32'(match_valid), 1);
        chk("t5_guard_price", 32'(match_price), 50);
        do_reset();
        load(2, 8'h60);
        send(1, 126, 1);
        send(0, 127, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_nowrap", 32'(match_valid), 0);
        end

        // T6: THROTTLE 0x20 admits one order every third cycle
        do_reset();
        in_valid = 1'b1; in_side = 1'b0; in_price = 7'd20; in_qty = 4'd1;
        load(1, 8'h20);
        for (int i = 0; i < 9; i++) begin
            chk("t6_throttle_ready", 32'(in_ready), int'(i % 3 == 0));
            step();
        end
        in_valid = 1'b0;

        // T6: asynchronous reset during a fill pulse
        do_reset();
        send(0, 40, 3);
        send(1, 40, 1);
        step();
        chk("t6_prefill", 32'(match_valid), 1);
        chk("t6_prefill_bids", 32'(bid_count), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_match", 32'(match_valid), 0);
        chk("t6_rst_bids", 32'(bid_count), 0);
        step();
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            in_valid = ($urandom_range(9, 0) < 7);
            in_side  = 1'($urandom_range(1, 0));
            in_price = ($urandom_range(4, 0) == 0) ? PRICE_W'($urandom_range(127, 0))
                                                   : PRICE_W'($urandom_range(60, 40));
            in_qty   = QTY_W'($urandom_range(15, 0));
            cb_load  = ($urandom_range(63, 0) == 0);
            cb_mode  = 2'($urandom_range(3, 0));
            cb_param = ($urandom_range(1, 0) == 0) ? 8'($urandom_range(40, 0))
                                                   : 8'($urandom_range(255, 0));
            if ($urandom_range(999, 0) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                chk("rand_async_rst", 32'(bid_count) + 32'(ask_count) + 32'(match_valid), 0);
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        in_valid = 1'b0;
        cb_load  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
